// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default timing and FSM state types.
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int UART_FRAME_BITS      = 10;
  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DEFAULT_WORD_WIDTH   = 16;

  // Byte transmitter states: one 8N1 frame
  typedef enum logic [1:0] {
    BYTE_IDLE,
    BYTE_START,
    BYTE_DATA,
    BYTE_STOP
  } byte_state_t;

  // Word sequencer states: IDLE waits for a word, WAIT tracks the byte on the line
  typedef enum logic {
    WORD_IDLE,
    WORD_WAIT
  } word_state_t;

  // Counter width that stays legal for a count range of 1
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter. Owns the registered tx line and all bit timing.
// byte_ready is also high during the last stop-bit cycle so that a following
// byte can start with no gap after the stop bit.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      byte_valid,
  input  logic [UART_DATA_BITS-1:0] byte_data,
  output logic                      byte_ready,
  output logic                      byte_done,
  output logic                      tx
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

  byte_state_t               state;
  logic [CNT_W-1:0]          clk_cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic                      tx_reg;
  logic                      bit_end;

  assign bit_end    = (clk_cnt == CNT_LAST);
  assign byte_done  = (state == BYTE_STOP) && bit_end;
  assign byte_ready = (state == BYTE_IDLE) || byte_done;
  assign tx         = tx_reg;

  // Frame sequencer: load on handshake, then walk start/data/stop one bit period each
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= BYTE_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else if (byte_valid && byte_ready) begin
      state     <= BYTE_START;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= byte_data;
      tx_reg    <= 1'b0;
    end else begin
      case (state)
        BYTE_IDLE: begin
          clk_cnt <= '0;
          tx_reg  <= 1'b1;
        end
        BYTE_START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= BYTE_DATA;
            tx_reg  <= shift_reg[0];
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        BYTE_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              state  <= BYTE_STOP;
              tx_reg <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= shift_reg >> 1;
              tx_reg    <= shift_reg[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        BYTE_STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= BYTE_IDLE;
            tx_reg  <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state  <= BYTE_IDLE;
          tx_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// Word-to-UART transmitter: latches one word and sends its bytes MSB byte first
// as back-to-back 8N1 frames. The first byte is handed to the byte transmitter
// straight from the input port so the start bit appears the cycle after accept.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int WORD_WIDTH   = DEFAULT_WORD_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  word_valid,
  input  logic [WORD_WIDTH-1:0] word,
  output logic                  word_ready,
  output logic                  busy,
  output logic                  tx
);

  localparam int NBYTES = WORD_WIDTH / UART_DATA_BITS;
  localparam int IDX_W  = cnt_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  generate
    if ((WORD_WIDTH % UART_DATA_BITS) != 0 || WORD_WIDTH == 0) begin : g_bad_width
      $error("uart_word_tx: WORD_WIDTH must be a non-zero multiple of 8");
    end
  endgenerate

  word_state_t               word_state;
  logic [WORD_WIDTH-1:0]     word_reg;
  logic [IDX_W-1:0]          byte_idx;
  logic                      busy_reg;
  logic                      accept;
  logic                      handoff;
  logic                      byte_valid;
  logic                      byte_ready;
  logic                      byte_done;
  logic [UART_DATA_BITS-1:0] byte_data;

  assign word_ready = !busy_reg;
  assign busy       = busy_reg;
  assign accept     = word_valid && word_ready && byte_ready;
  // Last stop-bit cycle of a byte that is not the final one: chain the next byte
  assign handoff    = (word_state == WORD_WAIT) && byte_done && (byte_idx != LAST_IDX);
  assign byte_valid = accept || handoff;
  // word_reg is kept left-aligned so the next byte to send is always its top byte
  assign byte_data  = busy_reg ? word_reg[WORD_WIDTH-1 -: UART_DATA_BITS]
                               : word[WORD_WIDTH-1 -: UART_DATA_BITS];

  // Word sequencer: latch remaining bytes on accept, count bytes, drop busy after the last
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_state <= WORD_IDLE;
      word_reg   <= '0;
      byte_idx   <= '0;
      busy_reg   <= 1'b0;
    end else begin
      case (word_state)
        WORD_IDLE: begin
          if (accept) begin
            word_reg   <= word << UART_DATA_BITS;
            byte_idx   <= '0;
            busy_reg   <= 1'b1;
            word_state <= WORD_WAIT;
          end
        end
        WORD_WAIT: begin
          if (byte_done) begin
            if (byte_idx == LAST_IDX) begin
              byte_idx   <= '0;
              word_reg   <= '0;
              busy_reg   <= 1'b0;
              word_state <= WORD_IDLE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              word_reg <= word_reg << UART_DATA_BITS;
            end
          end
        end
        default: begin
          word_state <= WORD_IDLE;
          busy_reg   <= 1'b0;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk       (clk),
    .rst       (rst),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .byte_done (byte_done),
    .tx        (tx)
  );

endmodule
